// File: rtl/des_final_perm_tx.sv
// DES output stage: final permutation IP^-1 on the pre-output block, then MSB-first OUT_W-bit beats.
// Optional odd-parity beat flag out_par when DES_TX_PARITY_EN is defined.
module des_final_perm_tx #(
    parameter int unsigned OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      preout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
`ifdef DES_TX_PARITY_EN
    output logic             out_par,
`endif
    output logic             busy
);

    localparam int unsigned BEATS = 64 / OUT_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state, state_d;
    logic [63:0]      sreg, sreg_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             last_beat;
    logic [63:0]      fp_block;

    // DES bit n (1 = leftmost) lives at vector index 64-n.
    function automatic logic [63:0] fp(input logic [63:0] d);
        logic [63:0] r;
        int unsigned src;
        r = '0;
        for (int unsigned row = 1; row <= 8; row++) begin
            for (int unsigned col = 1; col <= 8; col++) begin
                src = ((col % 2 == 1) ? (36 + 4 * col) : (4 * col)) + 1 - row;
                r[64 - (8 * (row - 1) + col)] = d[64 - src];
            end
        end
        return r;
    endfunction

    assign fp_block  = fp(preout);
    assign last_beat = (cnt == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            sreg  <= sreg_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state;
        sreg_d    = sreg;
        cnt_d     = cnt;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        out_data  = sreg[63 -: OUT_W];
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sreg_d  = fp_block;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = last_beat;
                if (out_ready) begin
                    if (last_beat) begin
                        // Last beat frees the register, so a waiting block loads with no bubble.
                        in_ready = 1'b1;
                        cnt_d    = '0;
                        if (in_valid) begin
                            sreg_d = fp_block;
                        end else begin
                            sreg_d  = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        sreg_d = sreg << OUT_W;
                        cnt_d  = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef DES_TX_PARITY_EN
    // Derived from registered sreg, so it tracks out_data and holds under backpressure.
    assign out_par = out_valid & ~(^out_data);
`endif

endmodule

// File: tb/tb_des_final_perm_tx.sv
// Randomized self-checking bench for des_final_perm_tx (OUT_W=8 and OUT_W=32 instances).
// Reference FP is built as the inverse of the standard DES initial permutation.
module tb_des_final_perm_tx;

    localparam logic [63:0] FIPS_IN = 64'h0A4CD99543423234;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] preout = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;

    logic        v32 = 1'b0;
    logic        r32;
    logic [63:0] p32 = '0;
    logic        ov32;
    logic        or32 = 1'b0;
    logic [31:0] od32;
    logic        ol32;
    logic        b32;

`ifdef DES_TX_PARITY_EN
    logic        out_par;
    logic        par32;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    des_final_perm_tx #(.OUT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .preout(preout), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
`ifdef DES_TX_PARITY_EN
        .out_par(out_par),
`endif
        .busy(busy)
    );

    des_final_perm_tx #(.OUT_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32),
        .preout(p32), .out_valid(ov32), .out_ready(or32),
        .out_data(od32), .out_last(ol32),
`ifdef DES_TX_PARITY_EN
        .out_par(par32),
`endif
        .busy(b32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // IP row r, col c takes input bit (58,60,62,64,57,59,61,63)[r] - 8(c-1); FP is its inverse.
    function automatic logic [63:0] ref_fp(input logic [63:0] x);
        int ip [64];
        logic [63:0] res;
        int first;
        for (int r = 1; r <= 8; r++) begin
            first = (r <= 4) ? (56 + 2 * r) : (47 + 2 * r);
            for (int c = 1; c <= 8; c++) ip[8 * (r - 1) + c - 1] = first - 8 * (c - 1);
        end
        res = '0;
        for (int k = 1; k <= 64; k++) res[64 - ip[k - 1]] = x[64 - k];
        return res;
    endfunction

    // Streams blocks with in_valid held while more remain; out_ready high with probability pct%.
    task automatic run_stream(input logic [63:0] blks [$], input int pct);
        int          bi = 0;
        int          beat = 0;
        int          cyc = 0;
        bit          done = 0;
        bit          stalled = 0;
        logic [63:0] exp;
        logic [7:0]  ebeat;
        logic [7:0]  prev_data = '0;
        logic        prev_last = 1'b0;
        @(negedge clk);
        in_valid  = 1'b1;
        preout    = blks[0];
        out_ready = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
        @(posedge clk);
        exp = ref_fp(blks[0]);
        bi  = 1;
        @(negedge clk);
        if (bi < blks.size()) preout = blks[bi];
        else in_valid = 1'b0;
        while (!done) begin
            out_ready = ($urandom_range(99) < pct);
            #1;
            ebeat = exp[63 - 8 * beat -: 8];
            check("out_valid", out_valid, 1);
            check("busy", busy, 1);
            check("out_data", out_data, ebeat);
            check("out_last", out_last, (beat == 7));
            check("in_ready", in_ready, (beat == 7) && out_ready);
`ifdef DES_TX_PARITY_EN
            check("out_par", out_par, ~(^ebeat));
`endif
            if (stalled) begin
                check("stall_data", out_data, prev_data);
                check("stall_last", out_last, prev_last);
            end
            prev_data = out_data;
            prev_last = out_last;
            @(posedge clk);
            if (out_ready) begin
                stalled = 0;
                beat++;
                if (beat == 8) begin
                    beat = 0;
                    if (bi < blks.size()) begin
                        exp = ref_fp(blks[bi]);
                        bi++;
                    end else begin
                        done = 1;
                    end
                end
            end else begin
                stalled = 1;
            end
            @(negedge clk);
            if (bi < blks.size()) begin
                in_valid = 1'b1;
                preout   = blks[bi];
            end else begin
                in_valid = 1'b0;
            end
            cyc++;
            if (cyc > 5000) begin
                check("stream_timeout", 1, 0);
                done = 1;
            end
        end
        out_ready = 1'b0;
        #1;
        check("end_out_valid", out_valid, 0);
        check("end_in_ready", in_ready, 1);
        check("end_busy", busy, 0);
    endtask

    initial begin
        logic [63:0] q [$];
        #1 rst_n = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
`ifdef DES_TX_PARITY_EN
        check("rst_out_par", out_par, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // FIPS vector at full rate, then explicit first/last beat constants.
        q = '{FIPS_IN};
        run_stream(q, 100);

        // FIPS vector with random backpressure.
        run_stream(q, 50);

        // One-hot sweep, back-to-back with zero bubble.
        q = {};
        for (int i = 0; i < 64; i++) q.push_back(64'd1 << i);
        run_stream(q, 100);

        // Two back-to-back random blocks, then random blocks under backpressure.
        q = '{{$urandom, $urandom}, {$urandom, $urandom}};
        run_stream(q, 100);
        q = {};
        for (int i = 0; i < 6; i++) q.push_back({$urandom, $urandom});
        run_stream(q, 60);

        // Reset after the 3rd beat.
        @(negedge clk);
        in_valid = 1'b1;
        preout   = FIPS_IN;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("fips_beat0", out_data, 8'h85);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_rst_valid", out_valid, 0);
        q = '{FIPS_IN};
        run_stream(q, 100);

        // OUT_W=32 instance on the FIPS vector.
        @(negedge clk);
        v32  = 1'b1;
        p32  = FIPS_IN;
        or32 = 1'b1;
        #1;
        check("w32_in_ready", r32, 1);
        @(posedge clk);
        @(negedge clk);
        v32 = 1'b0;
        check("w32_valid0", ov32, 1);
        check("w32_beat0", od32, 32'h85E81354);
        check("w32_last0", ol32, 0);
`ifdef DES_TX_PARITY_EN
        check("w32_par0", par32, ~(^od32));
`endif
        @(negedge clk);
        check("w32_valid1", ov32, 1);
        check("w32_beat1", od32, 32'h0F0AB405);
        check("w32_last1", ol32, 1);
        @(negedge clk);
        check("w32_idle", ov32, 0);
        check("w32_busy", b32, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
